drowsiness_detector1: RTL and testbench

DROWSINESS_DETECTOR1 -- requirements
Module: drowsiness_detector1

---
 rtl/drowsiness_detector1.sv | 127 ++++++++++++
 tb/tb_drowsiness_detector1.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/drowsiness_detector1.sv
// drowsiness_detector1: 2-layer fixed-point ANN (N_IN -> N_HID -> N_OUT), one input per clock MAC,
// with optional on-line update of the output-layer weights after each frame.
module drowsiness_detector1 #(
  parameter int N_IN  = 30,
  parameter int N_HID = 5,
  parameter int N_OUT = 3,
  parameter int DW    = 10
) (
  input  logic       Clock,
  input  logic       Rst,
  input  logic       Start,
  input  logic       training,
  input  logic [9:0] in [0:N_IN-1],
  input  logic [9:0] out_ann_real [0:N_OUT-1],
  output logic [9:0] out1 [0:N_OUT-1],
  output logic [9:0] out0 [0:N_HID-1]
);
  localparam int AW = 2*DW + 6;
  localparam int IB = $clog2(N_IN);
  localparam int HB = $clog2(N_HID);
  localparam logic signed [AW-1:0] WMAX = AW'(2**(DW-1) - 1);
  localparam logic signed [AW-1:0] WMIN = ~WMAX;
  typedef enum logic [2:0] {IDLE, HID, HACT, OUT, OACT, TRAIN} state_t;
  state_t r_state, w_next;
  logic [IB-1:0] r_idx;
  logic [9:0] r_x [0:N_IN-1];
  logic [9:0] r_t [0:N_OUT-1];
  logic r_trn;
  logic signed [DW-1:0] r_w0 [0:N_HID-1][0:N_IN-1];
  logic signed [DW-1:0] r_w1 [0:N_OUT-1][0:N_HID-1];
  logic signed [AW-1:0] r_hacc [0:N_HID-1];
  logic signed [AW-1:0] r_oacc [0:N_OUT-1];
  logic [9:0] r_out0 [0:N_HID-1];
  logic [9:0] r_out1 [0:N_OUT-1];

  function automatic logic signed [DW-1:0] w0_init(input int j, input int i);
    return DW'((3*i + 5*j) % 17 - 8);
  endfunction

  function automatic logic signed [DW-1:0] w1_init(input int k, input int j);
    return DW'((7*j + 3*k) % 17 - 8);
  endfunction

  // unsigned Q0.10 activation times signed weight, widened before multiplying
  function automatic logic signed [AW-1:0] mul(input logic [9:0] x, input logic signed [DW-1:0] w);
    return $signed({{(AW-10){1'b0}}, x}) * $signed({{(AW-DW){w[DW-1]}}, w});
  endfunction

  function automatic logic [9:0] act(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = (a >>> 10) + AW'(512);
    return s[AW-1] ? 10'd0 : (|s[AW-2:10]) ? 10'd1023 : s[9:0];
  endfunction

  function automatic logic signed [DW-1:0] upd(input logic signed [DW-1:0] w, input logic [9:0] t,
                                               input logic [9:0] y, input logic [9:0] h);
    logic signed [AW-1:0] d, s;
    d = $signed({{(AW-10){1'b0}}, t}) - $signed({{(AW-10){1'b0}}, y});
    s = $signed({{(AW-DW){w[DW-1]}}, w}) + ((d * $signed({{(AW-10){1'b0}}, h})) >>> 14);
    return s < WMIN ? WMIN[DW-1:0] : s > WMAX ? WMAX[DW-1:0] : s[DW-1:0];
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = Start ? HID : IDLE;
      HID:     w_next = (r_idx == IB'(N_IN-1)) ? HACT : HID;
      HACT:    w_next = OUT;
      OUT:     w_next = (r_idx[HB-1:0] == HB'(N_HID-1)) ? OACT : OUT;
      OACT:    w_next = TRAIN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) r_state <= Rst ? IDLE : w_next;

  always_ff @(posedge Clock) begin
    if (Rst) begin
      r_idx <= '0;
      r_trn <= 1'b0;
      for (int j = 0; j < N_HID; j++) begin
        r_out0[j] <= '0;
        r_hacc[j] <= '0;
        for (int i = 0; i < N_IN; i++) r_w0[j][i] <= w0_init(j, i);
      end
      for (int k = 0; k < N_OUT; k++) begin
        r_out1[k] <= '0;
        r_oacc[k] <= '0;
        for (int j = 0; j < N_HID; j++) r_w1[k][j] <= w1_init(k, j);
      end
    end else begin
      case (r_state)
        IDLE: if (Start) begin
          r_x   <= in;
          r_t   <= out_ann_real;
          r_trn <= training;
          r_idx <= '0;
          for (int j = 0; j < N_HID; j++) r_hacc[j] <= '0;
          for (int k = 0; k < N_OUT; k++) r_oacc[k] <= '0;
        end
        HID: begin
          for (int j = 0; j < N_HID; j++) r_hacc[j] <= r_hacc[j] + mul(r_x[r_idx], r_w0[j][r_idx]);
          r_idx <= (w_next == HACT) ? '0 : r_idx + IB'(1);
        end
        HACT: for (int j = 0; j < N_HID; j++) begin
          r_out0[j] <= act(r_hacc[j]);
          r_hacc[j] <= '0;
        end
        OUT: begin
          for (int k = 0; k < N_OUT; k++)
            r_oacc[k] <= r_oacc[k] + mul(r_out0[r_idx[HB-1:0]], r_w1[k][r_idx[HB-1:0]]);
          r_idx <= (w_next == OACT) ? '0 : r_idx + IB'(1);
        end
        OACT: for (int k = 0; k < N_OUT; k++) r_out1[k] <= act(r_oacc[k]);
        TRAIN: if (r_trn) begin
          for (int k = 0; k < N_OUT; k++)
            for (int j = 0; j < N_HID; j++)
              r_w1[k][j] <= upd(r_w1[k][j], r_t[k], r_out1[k], r_out0[j]);
        end
        default: ;
      endcase
    end
  end

  assign out0 = r_out0;
  assign out1 = r_out1;
endmodule

// File: tb/tb_drowsiness_detector1.sv
// tb_drowsiness_detector1: frame-level checks of the detector against an integer reference model.
module tb_drowsiness_detector1;
  localparam int NI = 30, NH = 5, NO = 3;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, trn = 1'b0;
  logic [9:0] x [NI];
  logic [9:0] tg [NO];
  logic [9:0] o1 [NO];
  logic [9:0] o0 [NH];

  drowsiness_detector1 dut (
    .Clock(clk), .Rst(rst), .Start(start), .training(trn),
    .in(x), .out_ann_real(tg), .out1(o1), .out0(o0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x [NI];
    int x2 [NI];
    int t [NO];
    bit trn;
    bit chg;
    int e0 [NH];
    int e1 [NO];
  } vec_t;

  vec_t tbl [$];
  vec_t sb [$];
  int n_chk = 0, n_pass = 0;
  int mw1 [NO][NH];
  int p0 [NH];
  int p1 [NO];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
  endtask

  function automatic int w0i(int j, int i); return (3*i + 5*j) % 17 - 8; endfunction
  function automatic int w1i(int k, int j); return (7*j + 3*k) % 17 - 8; endfunction
  function automatic int actm(int a);
    int s;
    s = (a >>> 10) + 512;
    return s < 0 ? 0 : s > 1023 ? 1023 : s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NO; k++) for (int j = 0; j < NH; j++) mw1[k][j] = w1i(k, j);
  endtask

  task automatic model(inout vec_t v);
    int a, u, w;
    for (int j = 0; j < NH; j++) begin
      a = 0;
      for (int i = 0; i < NI; i++) a += v.x[i] * w0i(j, i);
      v.e0[j] = actm(a);
    end
    for (int k = 0; k < NO; k++) begin
      a = 0;
      for (int j = 0; j < NH; j++) a += v.e0[j] * mw1[k][j];
      v.e1[k] = actm(a);
    end
    if (v.trn)
      for (int k = 0; k < NO; k++)
        for (int j = 0; j < NH; j++) begin
          u = ((v.t[k] - v.e1[k]) * v.e0[j]) >>> 14;
          w = mw1[k][j] + u;
          mw1[k][j] = w < -512 ? -512 : w > 511 ? 511 : w;
        end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < NH; j++) chk("reset_out0", int'(o0[j]), 0);
    for (int k = 0; k < NO; k++) chk("reset_out1", int'(o1[k]), 0);
    @(negedge clk);
    rst = 1'b0;
    p0 = '{default: 0};
    p1 = '{default: 0};
    model_reset();
  endtask

  // Start stays high through the frame so ignoring Start outside IDLE is exercised.
  task automatic frame(input vec_t v);
    @(negedge clk);
    for (int i = 0; i < NI; i++) x[i] = 10'(v.x[i]);
    for (int k = 0; k < NO; k++) tg[k] = 10'(v.t[k]);
    trn = v.trn;
    start = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (v.chg && c == 10) for (int i = 0; i < NI; i++) x[i] = 10'(v.x2[i]);
    end
    chk("out0_hold_n30", int'(o0[0]), p0[0]);
    @(posedge clk);
    #1;
    for (int j = 0; j < NH; j++) chk("out0", int'(o0[j]), sb[0].e0[j]);
    repeat (5) @(posedge clk);
    #1;
    chk("out1_hold_n36", int'(o1[0]), p1[0]);
    @(posedge clk);
    #1;
    for (int k = 0; k < NO; k++) chk("out1", int'(o1[k]), sb[0].e1[k]);
    p0 = sb[0].e0;
    p1 = sb[0].e1;
    sb.pop_front();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    vec_t v, vz, vt, v2, va, vb;
    for (int i = 0; i < NI; i++) x[i] = '0;
    for (int k = 0; k < NO; k++) tg[k] = '0;

    model_reset();
    for (int n = 0; n < 14; n++) begin
      v.chg = 1'b0;
      for (int i = 0; i < NI; i++) v.x[i] = (n < 4 || n >= 12) ? int'($urandom_range(1023)) : 1023;
      for (int k = 0; k < NO; k++)
        v.t[k] = (n < 4 || n >= 12) ? int'($urandom_range(1023)) :
                 (n < 10) ? ((k == 1) ? 0 : 1023) : ((k == 1) ? 1023 : 0);
      v.trn = (n < 4) ? 1'($urandom_range(1)) : (n < 12);
      model(v);
      tbl.push_back(v);
    end

    do_reset();

    for (int i = 0; i < NI; i++) vz.x[i] = 0;
    vz.t = '{0, 0, 0};
    vz.trn = 1'b0;
    vz.chg = 1'b0;
    vz.e0 = '{512, 512, 512, 512, 512};
    vz.e1 = '{510, 509, 508};
    frame(vz);
    frame(vz);

    vt = vz;
    vt.t = '{2, 999, 2};
    vt.trn = 1'b1;
    frame(vt);
    v2 = vz;
    v2.e1 = '{470, 546, 468};
    frame(v2);

    @(negedge clk);
    for (int i = 0; i < NI; i++) x[i] = '0;
    trn = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < NH; j++) chk("midrst_out0", int'(o0[j]), 0);
    for (int k = 0; k < NO; k++) chk("midrst_out1", int'(o1[k]), 0);
    @(negedge clk);
    rst = 1'b0;
    p0 = '{default: 0};
    p1 = '{default: 0};
    frame(vz);

    model_reset();
    for (int i = 0; i < NI; i++) begin
      va.x[i] = int'($urandom_range(1023));
      va.x2[i] = int'($urandom_range(1023));
    end
    va.t = '{0, 0, 0};
    va.trn = 1'b0;
    va.chg = 1'b1;
    model(va);
    vb = va;
    vb.x = va.x2;
    vb.chg = 1'b0;
    model(vb);
    frame(va);
    frame(vb);

    do_reset();
    foreach (tbl[n]) frame(tbl[n]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
